// File: rtl/lsu_pkg.sv
// Shared types and helpers for the multi-outstanding LSU.
// Optional build macro: LSU_PERF_CNT_EN (performance counters and per-slot ages).
package lsu_pkg;

  localparam int unsigned LSU_MAX_SLOTS = 16;

  typedef enum logic [1:0] {
    DC_LOAD  = 2'd0,
    DC_STORE = 2'd1,
    DC_ATOM  = 2'd2
  } dc_req_type_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_vector;
    logic       is_atomic;
  } lsu_slot_t;

  // Lowest index whose mask bit is clear; callers pad unused upper bits with 1.
  function automatic logic [4:0] first_free(input logic [LSU_MAX_SLOTS-1:0] mask);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = LSU_MAX_SLOTS - 1; i >= 0; i--) begin
      if (!mask[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lsu_tag_table.sv
// Pending-request table: slot index is the cache tag. Allocates lowest free slot,
// frees on response, flags responses to empty or out-of-range tags. Ages under LSU_PERF_CNT_EN.
module lsu_tag_table
  import lsu_pkg::*;
#(
  parameter int unsigned NUM_OUTSTANDING = 4,
  parameter int unsigned ID_W            = 8,
  parameter int unsigned TAG_W           = $clog2(NUM_OUTSTANDING)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_i,
  input  logic [4:0]       alloc_rd_i,
  input  logic             alloc_vec_i,
  input  logic             alloc_atomic_i,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             resp_valid_i,
  input  logic [ID_W-1:0]  resp_id_i,
  output logic             resp_hit_o,
  output logic [4:0]       resp_rd_o,
  output logic             resp_vec_o,
  output logic             resp_atomic_o,
`ifdef LSU_PERF_CNT_EN
  output logic [7:0]       resp_age_o,
`endif
  output logic             full_o,
  output logic             empty_o
);

  lsu_slot_t                    slots_q [NUM_OUTSTANDING];
  lsu_slot_t                    slots_d [NUM_OUTSTANDING];
  logic [NUM_OUTSTANDING-1:0]   valid_vec;
  logic [LSU_MAX_SLOTS-1:0]     pad_mask;
  logic [TAG_W-1:0]             resp_idx;
  logic                         in_range;

  always_comb begin
    pad_mask = '1;
    for (int i = 0; i < NUM_OUTSTANDING; i++) begin
      valid_vec[i] = slots_q[i].valid;
      pad_mask[i]  = slots_q[i].valid;
    end
    alloc_tag_o = TAG_W'(first_free(pad_mask));
    resp_idx    = TAG_W'(resp_id_i);
    in_range    = (32'(resp_id_i) < NUM_OUTSTANDING);
    resp_hit_o  = resp_valid_i && in_range && slots_q[resp_idx].valid;
    resp_rd_o     = resp_hit_o ? slots_q[resp_idx].rd        : 5'd0;
    resp_vec_o    = resp_hit_o ? slots_q[resp_idx].is_vector : 1'b0;
    resp_atomic_o = resp_hit_o ? slots_q[resp_idx].is_atomic : 1'b0;
  end

  // Free and allocate never target the same slot: allocation only picks registered-free slots.
  always_comb begin
    for (int i = 0; i < NUM_OUTSTANDING; i++) slots_d[i] = slots_q[i];
    if (resp_hit_o) slots_d[resp_idx] = '0;
    if (alloc_i) begin
      slots_d[alloc_tag_o] = '{valid: 1'b1, rd: alloc_rd_i,
                               is_vector: alloc_vec_i, is_atomic: alloc_atomic_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) slots_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) slots_q[i] <= slots_d[i];
    end
  end

  assign full_o  = &valid_vec;
  assign empty_o = ~|valid_vec;

`ifdef LSU_PERF_CNT_EN
  logic [7:0] age_q [NUM_OUTSTANDING];
  logic [7:0] age_d [NUM_OUTSTANDING];

  always_comb begin
    for (int i = 0; i < NUM_OUTSTANDING; i++) begin
      age_d[i] = age_q[i];
      if (alloc_i && (alloc_tag_o == TAG_W'(i))) age_d[i] = 8'd0;
      else if (slots_q[i].valid && (age_q[i] != 8'hFF)) age_d[i] = age_q[i] + 8'd1;
    end
    resp_age_o = resp_hit_o ? age_q[resp_idx] : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) age_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) age_q[i] <= age_d[i];
    end
  end
`endif

endmodule

// File: rtl/lsu_mo_core.sv
// Multi-outstanding LSU: combinational issue to the D-cache, tag-tracked loads/atomics,
// atomics serialised behind an empty table. LSU_PERF_CNT_EN adds perf counter ports.
module lsu_mo_core
  import lsu_pkg::*;
#(
  parameter int unsigned NUM_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 128,
  parameter int unsigned ID_W            = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_is_store,
  input  logic              req_is_vector,
  input  logic              req_is_atomic,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wstrb,
  input  logic [3:0]        req_vec_wmask,
  input  logic [4:0]        req_rd,
  output logic              req_ready,
  output logic              dc_req_valid,
  output logic [1:0]        dc_req_type,
  output logic [2:0]        dc_req_atomic_op,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic [DATA_W-1:0] dc_req_wdata,
  output logic [7:0]        dc_req_wstrb,
  output logic              dc_req_is_vector,
  output logic [3:0]        dc_req_vec_wmask,
  output logic [ID_W-1:0]   dc_req_id,
  input  logic              dc_req_ready,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_data,
  input  logic [ID_W-1:0]   dc_resp_id,
  input  logic              dc_resp_err,
  output logic              wb_valid,
  output logic              wb_is_vector,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_valid,
  output logic              stray_resp,
  output logic              busy,
  output logic              full
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stall_full,
  output logic [31:0]       perf_lat_sum
`endif
);

  localparam int unsigned TAG_W = $clog2(NUM_OUTSTANDING);

  logic             atomic_inflight_q, atomic_inflight_d;
  logic             accept_ok, accept, alloc, is_store_only, resp_ok;
  logic [TAG_W-1:0] alloc_tag;
  logic             hit, hit_vec, hit_atomic, tbl_full, tbl_empty;
  logic [4:0]       hit_rd;
  dc_req_type_e     req_type;
`ifdef LSU_PERF_CNT_EN
  logic [7:0]       hit_age;
`endif

  lsu_tag_table #(
    .NUM_OUTSTANDING(NUM_OUTSTANDING),
    .ID_W           (ID_W),
    .TAG_W          (TAG_W)
  ) u_tag_table (
    .clk           (clk),
    .rst           (rst),
    .alloc_i       (alloc),
    .alloc_rd_i    (req_rd),
    .alloc_vec_i   (req_is_vector),
    .alloc_atomic_i(req_is_atomic),
    .alloc_tag_o   (alloc_tag),
    .resp_valid_i  (dc_resp_valid),
    .resp_id_i     (dc_resp_id),
    .resp_hit_o    (hit),
    .resp_rd_o     (hit_rd),
    .resp_vec_o    (hit_vec),
    .resp_atomic_o (hit_atomic),
`ifdef LSU_PERF_CNT_EN
    .resp_age_o    (hit_age),
`endif
    .full_o        (tbl_full),
    .empty_o       (tbl_empty)
  );

  // Handshake: a request transfers on req_valid && req_ready; the same cycle the cache
  // sees dc_req_valid && dc_req_ready. Acceptance depends only on registered state.
  assign is_store_only = req_is_store && !req_is_atomic;

  always_comb begin
    accept_ok = 1'b0;
    if (!atomic_inflight_q) begin
      if (req_is_atomic)     accept_ok = tbl_empty;
      else if (req_is_store) accept_ok = 1'b1;
      else                   accept_ok = !tbl_full;
    end
  end

  always_comb begin
    req_type = DC_LOAD;
    if (req_is_atomic)     req_type = DC_ATOM;
    else if (req_is_store) req_type = DC_STORE;
  end

  assign req_ready    = dc_req_ready && accept_ok;
  assign dc_req_valid = req_valid && accept_ok;
  assign accept       = req_valid && req_ready;
  assign alloc        = accept && !is_store_only;

  assign dc_req_type      = req_type;
  assign dc_req_atomic_op = req_funct3;
  assign dc_req_addr      = req_addr;
  assign dc_req_wdata     = req_wdata;
  assign dc_req_wstrb     = req_wstrb;
  assign dc_req_is_vector = req_is_vector;
  assign dc_req_vec_wmask = req_vec_wmask;
  assign dc_req_id        = is_store_only ? '0 : ID_W'(alloc_tag);

  always_comb begin
    atomic_inflight_d = atomic_inflight_q;
    if (accept && req_is_atomic)  atomic_inflight_d = 1'b1;
    else if (hit && hit_atomic)   atomic_inflight_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) atomic_inflight_q <= 1'b0;
    else     atomic_inflight_q <= atomic_inflight_d;
  end

  assign resp_ok      = hit && !dc_resp_err;
  assign wb_valid     = resp_ok;
  assign err_valid    = hit && dc_resp_err;
  assign wb_rd        = hit_rd;
  assign wb_is_vector = resp_ok && hit_vec;
  assign wb_data      = resp_ok ? dc_resp_data : '0;
  assign stray_resp   = dc_resp_valid && !hit;
  assign busy         = !tbl_empty || atomic_inflight_q;
  assign full         = tbl_full;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads_q, perf_loads_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_lat_q, perf_lat_d;
  logic [32:0] lat_sum_wide;

  always_comb begin
    perf_loads_d = perf_loads_q;
    perf_stall_d = perf_stall_q;
    if (accept && !req_is_store && !req_is_atomic && (perf_loads_q != '1))
      perf_loads_d = perf_loads_q + 32'd1;
    if (req_valid && tbl_full && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
    lat_sum_wide = {1'b0, perf_lat_q} + {25'd0, hit_age};
    perf_lat_d   = lat_sum_wide[32] ? '1 : lat_sum_wide[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loads_q <= '0;
      perf_stall_q <= '0;
      perf_lat_q   <= '0;
    end else begin
      perf_loads_q <= perf_loads_d;
      perf_stall_q <= perf_stall_d;
      perf_lat_q   <= perf_lat_d;
    end
  end

  assign perf_loads      = perf_loads_q;
  assign perf_stall_full = perf_stall_q;
  assign perf_lat_sum    = perf_lat_q;
`endif

endmodule

// File: tb/tb_lsu_mo_core.sv
// Directed bench for lsu_mo_core: issue/response scoreboard with expected queues.
module tb_lsu_mo_core;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int IW   = 8;
  localparam int WB_W = 4 + 5 + DW;            // {wb_valid, err, stray, vec, rd, data}
  localparam int RQ_W = 2 + 3 + IW + AW + 8 + 1; // {type, op, id, addr, wstrb, vec}

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_is_store, req_is_vector, req_is_atomic;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_wstrb;
  logic [3:0]    req_vec_wmask;
  logic [4:0]    req_rd;
  logic          req_ready;
  logic          dc_req_valid;
  logic [1:0]    dc_req_type;
  logic [2:0]    dc_req_atomic_op;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_req_wdata;
  logic [7:0]    dc_req_wstrb;
  logic          dc_req_is_vector;
  logic [3:0]    dc_req_vec_wmask;
  logic [IW-1:0] dc_req_id;
  logic          dc_req_ready;
  logic          dc_resp_valid;
  logic [DW-1:0] dc_resp_data;
  logic [IW-1:0] dc_resp_id;
  logic          dc_resp_err;
  logic          wb_valid, wb_is_vector, err_valid, stray_resp, busy, full;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;

  logic [WB_W-1:0] exp_wb_q[$];
  logic [RQ_W-1:0] exp_req_q[$];
  int checks = 0;
  int errors = 0;

  lsu_mo_core #(.NUM_OUTSTANDING(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_is_vector(req_is_vector),
    .req_is_atomic(req_is_atomic), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_vec_wmask(req_vec_wmask),
    .req_rd(req_rd), .req_ready(req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_type(dc_req_type),
    .dc_req_atomic_op(dc_req_atomic_op), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
    .dc_req_is_vector(dc_req_is_vector), .dc_req_vec_wmask(dc_req_vec_wmask),
    .dc_req_id(dc_req_id), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_id(dc_resp_id),
    .dc_resp_err(dc_resp_err),
    .wb_valid(wb_valid), .wb_is_vector(wb_is_vector), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_valid(err_valid), .stray_resp(stray_resp), .busy(busy), .full(full)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_req(input logic [RQ_W-1:0] act, input logic [RQ_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dc_req: got %h expected %h", act, exp);
    end
  endtask

  task automatic check_wb(input logic [WB_W-1:0] act, input logic [WB_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL wb: got %h expected %h", act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] w);
    return {4{w}};
  endfunction

  // ---------------- expectation pushers ----------------
  task automatic exp_req(input logic [1:0] t, input logic [2:0] op, input int id,
                         input logic [AW-1:0] addr, input logic [7:0] ws, input logic vec);
    exp_req_q.push_back({t, op, IW'(id), addr, ws, vec});
  endtask

  task automatic exp_wb(input logic [4:0] rd, input logic vec, input logic [DW-1:0] d);
    exp_wb_q.push_back({1'b1, 1'b0, 1'b0, vec, rd, d});
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [WB_W-1:0] e_wb, a_wb;
    logic [RQ_W-1:0] e_rq;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dc_req_valid && dc_req_ready) begin
          if (exp_req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dc_req_unexpected: got addr %h with no expected request", dc_req_addr);
          end else begin
            e_rq = exp_req_q.pop_front();
            check_req({dc_req_type, dc_req_atomic_op, dc_req_id, dc_req_addr, dc_req_wstrb,
                       dc_req_is_vector}, e_rq);
          end
        end
        if (wb_valid || err_valid || stray_resp) begin
          if (exp_wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: got wb=%b err=%b stray=%b rd=%0d with nothing expected",
                     wb_valid, err_valid, stray_resp, wb_rd);
          end else begin
            e_wb = exp_wb_q.pop_front();
            // vec/data are only meaningful on a writeback, rd on writeback or error
            a_wb = {wb_valid, err_valid, stray_resp,
                    e_wb[WB_W-1] ? wb_is_vector : 1'b0,
                    (e_wb[WB_W-1] || e_wb[WB_W-2]) ? wb_rd : 5'd0,
                    e_wb[WB_W-1] ? wb_data : {DW{1'b0}}};
            check_wb(a_wb, e_wb);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    dc_resp_valid = 1'b0;
    dc_resp_err   = 1'b0;
  endtask

  task automatic drive_req(input logic st, input logic at, input logic vec, input logic [2:0] f3,
                           input logic [AW-1:0] addr, input logic [4:0] rd,
                           input logic [7:0] ws);
    req_valid     = 1'b1;
    req_is_store  = st;
    req_is_atomic = at;
    req_is_vector = vec;
    req_funct3    = f3;
    req_addr      = addr;
    req_wdata     = mk(addr);
    req_wstrb     = ws;
    req_vec_wmask = 4'hF;
    req_rd        = rd;
  endtask

  task automatic wait_accept(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (req_ready) done = 1'b1;
      step();
    end
    req_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s: req_ready never rose, got 0 expected 1", name);
    end
  endtask

  task automatic load(input logic [4:0] rd, input logic [AW-1:0] addr, input logic vec,
                      input int exp_id);
    exp_req(2'd0, 3'd0, exp_id, addr, 8'h00, vec);
    drive_req(1'b0, 1'b0, vec, 3'd0, addr, rd, 8'h00);
    wait_accept($sformatf("load_rd%0d", rd));
  endtask

  task automatic drive_resp(input int id, input logic [DW-1:0] d, input logic err);
    dc_resp_valid = 1'b1;
    dc_resp_id    = IW'(id);
    dc_resp_data  = d;
    dc_resp_err   = err;
  endtask

  task automatic rsp_ok(input int id, input logic [4:0] rd, input logic vec,
                        input logic [DW-1:0] d);
    exp_wb(rd, vec, d);
    drive_resp(id, d, 1'b0);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_is_vector = 1'b0; req_is_atomic = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_vec_wmask = '0;
    req_rd = '0; dc_req_ready = 1'b0;
    dc_resp_valid = 1'b0; dc_resp_data = '0; dc_resp_id = '0; dc_resp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_full", full, 1'b0);
    check1("rst_req_ready", req_ready, 1'b0);
    check1("rst_dc_req_valid", dc_req_valid, 1'b0);
    check1("rst_wb_valid", wb_valid, 1'b0);
    check1("rst_err_valid", err_valid, 1'b0);
    check1("rst_stray", stray_resp, 1'b0);
    rst = 1'b0;
    dc_req_ready = 1'b1;
    step();

    // four loads fill the table; out-of-order return 3,0,2,1
    load(5'd1, 32'h100, 1'b0, 0);
    load(5'd2, 32'h110, 1'b0, 1);
    load(5'd3, 32'h120, 1'b0, 2);
    load(5'd4, 32'h130, 1'b0, 3);
    #1;
    check1("t1_full", full, 1'b1);
    check1("t1_busy", busy, 1'b1);
    drive_req(1'b0, 1'b0, 1'b0, 3'd0, 32'h140, 5'd5, 8'h00);
    #1;
    check1("t1_fifth_ready", req_ready, 1'b0);
    check1("t1_fifth_dc_valid", dc_req_valid, 1'b0);
    step();
    req_valid = 1'b0;
    rsp_ok(3, 5'd4, 1'b0, mk(32'hD000_0003));
    rsp_ok(0, 5'd1, 1'b0, mk(32'hD000_0000));
    rsp_ok(2, 5'd3, 1'b0, mk(32'hD000_0002));
    rsp_ok(1, 5'd2, 1'b0, mk(32'hD000_0001));
    #1;
    check1("t1_drained_busy", busy, 1'b0);
    check1("t1_drained_full", full, 1'b0);

    // full table: response id 0 and new load in the same cycle
    load(5'd6, 32'h200, 1'b0, 0);
    load(5'd7, 32'h210, 1'b0, 1);
    load(5'd8, 32'h220, 1'b0, 2);
    load(5'd9, 32'h230, 1'b0, 3);
    exp_req(2'd0, 3'd0, 0, 32'h240, 8'h00, 1'b0);
    drive_req(1'b0, 1'b0, 1'b0, 3'd0, 32'h240, 5'd10, 8'h00);
    exp_wb(5'd6, 1'b0, mk(32'hE000_0006));
    drive_resp(0, mk(32'hE000_0006), 1'b0);
    #1;
    check1("t2_same_cycle_ready", req_ready, 1'b0);
    step();
    wait_accept("t2_reuse_slot0");
    rsp_ok(1, 5'd7, 1'b0, mk(32'hE000_0007));
    rsp_ok(2, 5'd8, 1'b0, mk(32'hE000_0008));
    rsp_ok(3, 5'd9, 1'b0, mk(32'hE000_0009));
    rsp_ok(0, 5'd10, 1'b0, mk(32'hE000_000A));

    // atomic drains pending loads, then blocks a store until it returns
    load(5'd11, 32'h300, 1'b0, 0);
    load(5'd12, 32'h310, 1'b0, 1);
    drive_req(1'b0, 1'b1, 1'b0, 3'd1, 32'h400, 5'd13, 8'h00);
    #1;
    check1("t3_atom_stall0", req_ready, 1'b0);
    rsp_ok(0, 5'd11, 1'b0, mk(32'hA000_000B));
    #1;
    check1("t3_atom_stall1", req_ready, 1'b0);
    rsp_ok(1, 5'd12, 1'b0, mk(32'hA000_000C));
    exp_req(2'd2, 3'd1, 0, 32'h400, 8'h00, 1'b0);
    wait_accept("t3_atomic");
    #1;
    check1("t3_atom_busy", busy, 1'b1);
    drive_req(1'b1, 1'b0, 1'b0, 3'd0, 32'h500, 5'd0, 8'h0F);
    #1;
    check1("t3_store_blocked", req_ready, 1'b0);
    rsp_ok(0, 5'd13, 1'b0, mk(32'h0BAD_CAFE));
    exp_req(2'd1, 3'd0, 0, 32'h500, 8'h0F, 1'b0);
    wait_accept("t4_store");
    #1;
    check1("t4_store_no_slot_busy", busy, 1'b0);
    check1("t4_store_no_slot_full", full, 1'b0);

    // error response frees slot 1, vector load reuses it
    load(5'd14, 32'h600, 1'b0, 0);
    load(5'd15, 32'h610, 1'b1, 1);
    exp_wb_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 5'd15, {DW{1'b0}}});
    drive_resp(1, mk(32'hEEEE_EEEE), 1'b1);
    step();
    load(5'd16, 32'h620, 1'b1, 1);
    rsp_ok(0, 5'd14, 1'b0, mk(32'h1400_0000));
    rsp_ok(1, 5'd16, 1'b1, mk(32'h1600_0000));

    // reset with two loads pending; later responses are stray
    load(5'd17, 32'h700, 1'b0, 0);
    load(5'd18, 32'h710, 1'b0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check1("t6_busy_after_rst", busy, 1'b0);
    check1("t6_full_after_rst", full, 1'b0);
    exp_wb_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 5'd0, {DW{1'b0}}});
    drive_resp(0, mk(32'h1700_0000), 1'b0);
    step();
    exp_wb_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 5'd0, {DW{1'b0}}});
    drive_resp(7, mk(32'h7777_7777), 1'b0);
    step();
    #1;
    check1("t6_busy_after_stray", busy, 1'b0);

    repeat (3) step();
    check1("wb_queue_empty", exp_wb_q.size() == 0, 1'b1);
    check1("req_queue_empty", exp_req_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mo_core.md
Name: lsu_mo_core

Overview:
- Multi-outstanding successor to the single-outstanding core LSU.
- Accepts scalar/vector loads, stores and atomics from the pipeline and issues them to the L1 data cache port.
- Tracks up to NUM_OUTSTANDING loads/atomics in a tag table; cache responses may return out of order and are written back by tag.
- Sits between the execute stage and the L1 D-cache port of a compute unit. Mailbox traffic stays outside this block.

Parameters:
- NUM_OUTSTANDING, 4, pending-table entries (2..16); slot index doubles as the request tag.
- ADDR_W, 32, address width.
- DATA_W, 128, request/response data width (vector line).
- ID_W, 8, cache request/response ID width; must be >= clog2(NUM_OUTSTANDING).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  1  pipeline request valid
- req_is_store  in  1  store
- req_is_vector  in  1  vector access
- req_is_atomic  in  1  atomic RMW; op in req_funct3
- req_funct3  in  3  width / atomic op
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store/atomic source
- req_wstrb  in  8  scalar byte strobe
- req_vec_wmask  in  4  vector lane mask
- req_rd  in  5  destination register
- req_ready  out  1  request accepted when req_valid && req_ready
- dc_req_valid  out  1  cache request valid
- dc_req_type  out  2  0=LOAD, 1=STORE, 2=ATOM
- dc_req_atomic_op  out  3  atomic op
- dc_req_addr  out  ADDR_W  address
- dc_req_wdata  out  DATA_W  write data
- dc_req_wstrb  out  8  strobe
- dc_req_is_vector  out  1  vector
- dc_req_vec_wmask  out  4  lane mask
- dc_req_id  out  ID_W  zero-extended slot tag (0 for stores)
- dc_req_ready  in  1  cache accepts
- dc_resp_valid  in  1  response valid
- dc_resp_data  in  DATA_W  response / old value
- dc_resp_id  in  ID_W  response tag
- dc_resp_err  in  1  response error
- wb_valid  out  1  writeback pulse
- wb_is_vector  out  1  writeback is vector
- wb_rd  out  5  writeback register
- wb_data  out  DATA_W  writeback data
- err_valid  out  1  one-cycle pulse on error response; wb_rd carries rd
- stray_resp  out  1  one-cycle pulse when a response hits an invalid slot
- busy  out  1  any slot valid or atomic in flight
- full  out  1  all slots valid

Behaviour:
- Reset: table cleared, atomic_inflight=0, all outputs 0.
- Issue path is combinational pass-through: dc_req_valid = req_valid && accept_ok; dc_req_* mirror the req_* inputs.
- req_ready = dc_req_ready && accept_ok.
- accept_ok, evaluated on registered state only:
  - store: !atomic_inflight.
  - load: !atomic_inflight && !full.
  - atomic: !atomic_inflight && no slot valid, i.e. atomics drain and serialise.
- A slot freed by a response in cycle N is allocatable in N+1, never in N. A response and an acceptance in the same cycle are both processed.
- Allocation picks the lowest-index free slot.
- Each slot records valid, rd, is_vector, is_atomic.
- Stores allocate no slot and produce no writeback.
- Atomic acceptance: allocates a slot and sets atomic_inflight. Both clear on that slot's response, and wb_data carries the old value.
- Response handling (single-cycle, combinational to wb):
  - Slot valid, no error: wb_valid=1, wb_rd/wb_is_vector from the slot, wb_data=dc_resp_data, slot cleared.
  - Error: wb_valid=0, err_valid=1, slot cleared.
  - Slot invalid or tag >= NUM_OUTSTANDING: stray_resp=1, no state change.
- Latency: writeback is in the same cycle as dc_resp_valid. Minimum load round trip is fully determined by the cache.
- Reset mid-operation clears the table. Responses arriving later are reported as stray_resp.

Optional Feature:
- LSU_PERF_CNT_EN defined: adds three 32-bit saturating counters, each as an output port.
  - perf_loads: accepted loads.
  - perf_stall_full: cycles with req_valid && full.
  - perf_lat_sum: sum of per-slot outstanding cycles; each slot has an 8-bit saturating age counter, added on response.
  - Counters reset to 0.
- Undefined: counters, ports and age logic are absent. Behaviour is otherwise identical.

Decomposition:
- lsu_pkg holds:
  - dc_req_type_e (LOAD/STORE/ATOM).
  - Struct lsu_slot_t {valid, rd, is_vector, is_atomic}.
  - Function first_free(mask).
- Sub-module lsu_tag_table owns the slot array, allocation, free-on-response, full/empty and stray detection.
- lsu_mo_core holds the issue arbitration and atomic serialisation.

Test Plan:
- 4 loads to rd 1..4, cache returns ids 3,0,2,1 → wb in that order with rd 4,1,3,2. full=1 after the 4th load; a 5th load sees req_ready=0.
- Table full, response id 0 arrives with a new load valid → load held that cycle, accepted next cycle with dc_req_id=0.
- 2 loads pending, then atomic (funct3=1) → atomic stalls until both responses return. It then issues type=2; a subsequent store is blocked until the atomic response, and wb_data equals the old value.
- Store with req_wstrb=8'h0F → dc_req_type=1, dc_req_id=0, no slot used, no wb_valid.
- Load id 1 returns with dc_resp_err=1 → err_valid=1 with wb_rd=rd, wb_valid=0, slot freed.
- 2 loads pending, assert rst for 1 cycle, then respond id 0 → stray_resp=1, no wb, busy=0.
